// File: rtl/gv_button_conditioner.sv
// Fret-button front end: per-lane synchroniser, debounce and edge pulses, then a
// chord collector that merges presses landing within CHORD_WIN cycles into one event.
module gv_button_conditioner #(
  parameter int NUM_BTN   = 4,
  parameter int DB_CYCLES = 1000,
  parameter int CHORD_WIN = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_BTN-1:0] button_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic               chord_valid,
  output logic [NUM_BTN-1:0] chord_mask,
  output logic               chord_busy
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam int TW = (CHORD_WIN > 1) ? $clog2(CHORD_WIN) : 1;
  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [TW-1:0] WIN_LAST = TW'(CHORD_WIN - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

  logic [NUM_BTN-1:0] sync_p0, sync_p1;
  logic [CW-1:0]      db_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] flip;

  state_t             state, state_nx;
  logic [NUM_BTN-1:0] mask, mask_nx, chord_mask_nx;
  logic [TW-1:0]      timer, timer_nx;
  logic               chord_valid_nx;

  // Stage p0/p1: two-flop synchroniser, free-running even while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= button_in;
      sync_p1 <= sync_p0;
    end
  end

  always_comb begin
    flip = '0;
    for (int i = 0; i < NUM_BTN; i++)
      flip[i] = (sync_p1[i] != btn_level[i]) && (db_cnt[i] == DB_LAST);
  end

  // Debounce stage: level toggles only after DB_CYCLES consecutive mismatching samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BTN; i++) db_cnt[i] <= '0;
      btn_level     <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
    end else if (!en) begin
      for (int i = 0; i < NUM_BTN; i++) db_cnt[i] <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if ((sync_p1[i] == btn_level[i]) || flip[i])
          db_cnt[i] <= '0;
        else
          db_cnt[i] <= db_cnt[i] + CW'(1);
      end
      btn_level     <= btn_level ^ flip;
      press_pulse   <= flip & ~btn_level;
      release_pulse <= flip & btn_level;
    end
  end

  always_comb begin
    state_nx       = state;
    mask_nx        = mask;
    timer_nx       = timer;
    chord_valid_nx = 1'b0;
    chord_mask_nx  = chord_mask;
    if (!en) begin
      state_nx = IDLE;
      mask_nx  = '0;
      timer_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          if (|press_pulse) begin
            state_nx = COLLECT;
            mask_nx  = press_pulse;
            timer_nx = '0;
          end
        end
        COLLECT: begin
          mask_nx  = mask | press_pulse;
          timer_nx = timer + TW'(1);
          if (timer == WIN_LAST) begin
            state_nx       = EMIT;
            chord_valid_nx = 1'b1;
            chord_mask_nx  = mask | press_pulse;
            timer_nx       = '0;
          end
        end
        EMIT: begin
          // A press landing on the emit cycle opens the next chord immediately
          if (|press_pulse) begin
            state_nx = COLLECT;
            mask_nx  = press_pulse;
          end else begin
            state_nx = IDLE;
            mask_nx  = '0;
          end
          timer_nx = '0;
        end
        default: begin
          state_nx = IDLE;
          mask_nx  = '0;
          timer_nx = '0;
        end
      endcase
    end
  end

  // Chord stage: state, window timer and the registered chord strobe/mask
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mask        <= '0;
      timer       <= '0;
      chord_valid <= 1'b0;
      chord_mask  <= '0;
    end else begin
      state       <= state_nx;
      mask        <= mask_nx;
      timer       <= timer_nx;
      chord_valid <= chord_valid_nx;
      chord_mask  <= chord_mask_nx;
    end
  end

  assign chord_busy = (state != IDLE);

endmodule

// File: tb/tb_gv_button_conditioner.sv
// Directed bench for gv_button_conditioner (DB_CYCLES=4, CHORD_WIN=3): a per-cycle
// vector table for debounce/chord/disable behaviour, then an async reset sequence.
module tb_gv_button_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] button_in;
  logic [3:0] btn_level, press_pulse, release_pulse, chord_mask;
  logic       chord_valid, chord_busy;

  int n_cmp = 0;
  int n_bad = 0;

  gv_button_conditioner #(
    .NUM_BTN  (4),
    .DB_CYCLES(4),
    .CHORD_WIN(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .button_in    (button_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .chord_valid  (chord_valid),
    .chord_mask   (chord_mask),
    .chord_busy   (chord_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] btn;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic       cv;
    logic [3:0] msk;
    logic       bsy;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int n, input logic e, input logic [3:0] b,
                     input logic [3:0] l, input logic [3:0] p, input logic [3:0] r,
                     input logic c, input logic [3:0] m, input logic y);
    vec_t v;
    v.en = e; v.btn = b; v.lvl = l; v.prs = p; v.rel = r; v.cv = c; v.msk = m; v.bsy = y;
    for (int k = 0; k < n; k++) vq.push_back(v);
  endtask

  task automatic check(input string name, input int step, input logic [3:0] act,
                       input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at step %0d: got %b, want %b", name, step, act, exp);
    end
  endtask

  task automatic check_all(input int step, input logic [3:0] l, input logic [3:0] p,
                           input logic [3:0] r, input logic c, input logic [3:0] m,
                           input logic y);
    check("btn_level", step, btn_level, l);
    check("press_pulse", step, press_pulse, p);
    check("release_pulse", step, release_pulse, r);
    check("chord_valid", step, {3'b000, chord_valid}, {3'b000, c});
    check("chord_mask", step, chord_mask, m);
    check("chord_busy", step, {3'b000, chord_busy}, {3'b000, y});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //  n  en btn      lvl      prs      rel      cv mask     busy
    add(2, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0); // 0-1 idle
    add(2, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0); // 2-3 bounce
    add(2, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0); // 4-5
    add(2, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0); // 6-7 final lane0 change
    add(3, 1, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0); // 8-10 lane2 pressed
    add(1, 1, 4'b0101, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0000, 0); // 11 press lane0 (t)
    add(1, 1, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0000, 1); // 12
    add(1, 1, 4'b0101, 4'b0101, 4'b0100, 4'b0000, 0, 4'b0000, 1); // 13 press lane2 (t+2)
    add(1, 1, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 0, 4'b0000, 1); // 14
    add(1, 1, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 1, 4'b0101, 1); // 15 merged chord
    add(1, 1, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 0, 4'b0101, 0); // 16
    add(5, 1, 4'b0100, 4'b0101, 4'b0000, 4'b0000, 0, 4'b0101, 0); // 17-21 drop lane0
    add(1, 1, 4'b0100, 4'b0100, 4'b0000, 4'b0001, 0, 4'b0101, 0); // 22 release lane0
    add(1, 1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 0, 4'b0101, 0); // 23
    add(4, 1, 4'b0110, 4'b0100, 4'b0000, 4'b0000, 0, 4'b0101, 0); // 24-27 lane1 pressed
    add(1, 1, 4'b1110, 4'b0100, 4'b0000, 4'b0000, 0, 4'b0101, 0); // 28 lane3 pressed
    add(1, 1, 4'b1110, 4'b0110, 4'b0010, 4'b0000, 0, 4'b0101, 0); // 29 press lane1
    add(3, 1, 4'b1110, 4'b0110, 4'b0000, 4'b0000, 0, 4'b0101, 1); // 30-32
    add(1, 1, 4'b1110, 4'b1110, 4'b1000, 4'b0000, 1, 4'b0010, 1); // 33 emit + lane3 press
    add(3, 1, 4'b1110, 4'b1110, 4'b0000, 4'b0000, 0, 4'b0010, 1); // 34-36 new chord
    add(1, 1, 4'b1110, 4'b1110, 4'b0000, 4'b0000, 1, 4'b1000, 1); // 37
    add(1, 1, 4'b1110, 4'b1110, 4'b0000, 4'b0000, 0, 4'b1000, 0); // 38
    add(5, 1, 4'b1111, 4'b1110, 4'b0000, 4'b0000, 0, 4'b1000, 0); // 39-43 lane0 again
    add(1, 1, 4'b1111, 4'b1111, 4'b0001, 4'b0000, 0, 4'b1000, 0); // 44
    add(1, 1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 0, 4'b1000, 1); // 45 collecting
    add(1, 0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 0, 4'b1000, 0); // 46 disabled
    add(1, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 0, 4'b1000, 0); // 47 bounce while off
    add(1, 0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 0, 4'b1000, 0); // 48
    add(7, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 0, 4'b1000, 0); // 49-55
    add(3, 1, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 0, 4'b1000, 0); // 56-58 re-enabled
    add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 4'b1000, 0); // 59 release all
    add(2, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 4'b1000, 0); // 60-61

    rst = 1'b1;
    en = 1'b1;
    button_in = 4'b0000;
    repeat (3) tick();
    check_all(-1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
    rst = 1'b0;

    for (int s = 0; s < vq.size(); s++) begin
      en = vq[s].en;
      button_in = vq[s].btn;
      tick();
      check_all(s, vq[s].lvl, vq[s].prs, vq[s].rel, vq[s].cv, vq[s].msk, vq[s].bsy);
    end

    // Bring all lanes up, open a chord window, then abort with an async reset
    en = 1'b1;
    button_in = 4'b1111;
    repeat (5) tick();
    check_all(100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b0);
    tick();
    check_all(101, 4'b1111, 4'b1111, 4'b0000, 1'b0, 4'b1000, 1'b0);
    tick();
    check_all(102, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_all(103, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_all(104 + k, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_all(110 + k, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gv_button_conditioner.md
Name: gv_button_conditioner

Overview:
- Input-side counterpart to the game's display path: turns the raw fret buttons from the breakout pins into clean, synchronised game events.
- Per lane, synchronises the raw button, debounces it, and emits one-cycle press and release pulses.
- Merges presses that land within a short window into a single chord event with a lane mask.
- Sits between the GPIO input pins and the Guitar Villains game logic, clocked by the system clk.

Parameters:
- NUM_BTN, 4, number of button lanes.
- DB_CYCLES, 1000, consecutive stable cycles required before a lane's debounced level changes (>=2).
- CHORD_WIN, 200, collection window in cycles after the first press of a chord (>=1).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  block enable (active high, driven from inverted chip select); 0 freezes event generation.
- button_in  input  NUM_BTN  raw, asynchronous button levels (1 = pressed).
- btn_level  output  NUM_BTN  debounced level per lane.
- press_pulse  output  NUM_BTN  one-cycle pulse when a lane's btn_level rises.
- release_pulse  output  NUM_BTN  one-cycle pulse when a lane's btn_level falls.
- chord_valid  output  1  one-cycle strobe: chord complete.
- chord_mask  output  NUM_BTN  lanes pressed in the last completed chord; held until the next chord_valid.
- chord_busy  output  1  high while a chord window is open.

Behaviour:
- Reset (rst=1, async): synchronisers, debounce counters, btn_level, press_pulse, release_pulse, chord_valid, chord_mask and chord_busy are all 0; chord FSM is in IDLE. Asserting rst mid-operation aborts everything with no pulse emitted.
- Synchroniser: two flops per lane, giving sync[i].
- Debounce, per lane:
  - Counter of width clog2(DB_CYCLES).
  - sync[i] == btn_level[i]: counter is cleared.
  - sync[i] != btn_level[i] and counter < DB_CYCLES-1: counter increments.
  - sync[i] != btn_level[i] and counter == DB_CYCLES-1: btn_level[i] toggles and counter clears.
  - Any bounce back to the old level restarts the count from 0.
- Latency: a raw change captured at edge 0 and held stable updates btn_level at edge DB_CYCLES+1.
- Edge pulses:
  - press_pulse[i] and release_pulse[i] are registered and asserted in the same cycle btn_level[i] changes; high for exactly one cycle.
  - Lanes are independent; any combination may pulse together.
- Chord FSM (states IDLE, COLLECT, EMIT):
  - IDLE: if any press_pulse, go to COLLECT with mask <= press_pulse and timer <= 0.
  - COLLECT: mask |= press_pulse each cycle and timer increments. At timer == CHORD_WIN-1 (after that cycle's OR), go to EMIT.
  - EMIT: chord_valid=1 for one cycle and chord_mask <= mask (registered, visible the same cycle). A press_pulse arriving in EMIT starts a new COLLECT with that press, so it is not lost. Otherwise return to IDLE.
  - Chord latency: first press_pulse high in cycle t → chord_valid high in cycle t+CHORD_WIN+1.
  - chord_busy = (state != IDLE).
  - Releases never affect the chord FSM.
  - Repeat press of the same lane inside a window: mask is unchanged; still one chord.
- en=0:
  - Synchronisers keep running.
  - Debounce counters held at 0 and btn_level frozen.
  - press_pulse, release_pulse and chord_valid forced to 0.
  - FSM forced to IDLE with mask discarded; chord_mask retains its last value.
- en rising: debounce restarts from frozen levels. A button held through the disable produces a press after DB_CYCLES stable cycles if it differs from the frozen level.

Test Plan:
(DB_CYCLES=4, CHORD_WIN=3, NUM_BTN=4)
- Reset: assert rst with button_in=4'b1111 mid-stream → all outputs 0 asynchronously; hold rst 5 cycles → still 0.
- Debounce: button_in[0] toggles 1,0,1 every 2 cycles, then held 1 → btn_level[0] rises exactly 5 edges after the final change; exactly one press_pulse[0]; no release_pulse.
- Release: from btn_level=4'b0001, drop button_in[0] → release_pulse[0] for one cycle 5 edges later; btn_level=0.
- Chord merge: lane 0 press_pulse in cycle t, lane 2 in t+2 → single chord_valid in cycle t+4 with chord_mask=4'b0101; chord_busy high for t+1..t+4.
- Split chords: lane 0 at t, lane 1 at t+6 → chord_valid at t+4 (mask 4'b0001) and at t+10 (mask 4'b0010). Press exactly in an EMIT cycle starts a new chord.
- Disable: en=0 during COLLECT → no chord_valid, chord_busy drops next cycle, chord_mask keeps its previous value. en=0 with bouncing input → no pulses.
